// File: rtl/wb_spi_mem.sv
// Wishbone classic slave to single-bit SPI memory: one SPI frame per bus cycle (READ 0x03 / WRITE 0x02).
// Ack arrives 2N+1 cycles after capture (N = frame bits); the request is latched, so stb may drop early.
module wb_spi_mem #(
   parameter int ADDR_BITS = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);
   localparam int TOT = 8 + ADDR_BITS + 32;
   localparam int CW  = $clog2(TOT + 1);

   typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DONE} state_t;
   typedef struct packed {
      logic       ok;
      logic [1:0] off;
      logic [2:0] nbytes;
   } lane_t;

   state_t         state, state_nxt;
   lane_t          lane;
   logic [TOT-1:0] tx_q;
   logic [CW-1:0]  cnt_q;
   logic           phase_q;
   logic           we_q;
   logic [31:0]    rx_q;
   logic [31:0]    rx_nxt;
   logic [31:0]    wr_swap;
   logic [31:0]    wr_data;
   logic           req;
   logic           last_bit;
   logic           unused_adr;

   assign req        = wb_cyc_i & wb_stb_i;
   assign last_bit   = (state == SHIFT) && phase_q && (cnt_q == CW'(1));
   assign rx_nxt     = {rx_q[30:0], spi_miso};
   assign unused_adr = ^wb_adr_i;

   // Lanes go out in increasing address order, so byte-swap and left-justify the first lane.
   assign wr_swap = {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]};
   assign wr_data = wr_swap << {lane.off, 3'b000};

   always_comb begin
      lane = '{1'b1, 2'd0, 3'd4};
      if (wb_we_i) begin
         case (wb_sel_i)
            4'b0001: lane = '{1'b1, 2'd0, 3'd1};
            4'b0010: lane = '{1'b1, 2'd1, 3'd1};
            4'b0100: lane = '{1'b1, 2'd2, 3'd1};
            4'b1000: lane = '{1'b1, 2'd3, 3'd1};
            4'b0011: lane = '{1'b1, 2'd0, 3'd2};
            4'b1100: lane = '{1'b1, 2'd2, 3'd2};
            4'b1111: lane = '{1'b1, 2'd0, 3'd4};
            default: lane.ok = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      spi_cs_n  = 1'b1;
      spi_sck   = 1'b0;
      spi_mosi  = 1'b0;
      wb_ack_o  = 1'b0;
      case (state)
         IDLE: begin
            if (req) state_nxt = lane.ok ? SELECT : DONE;
         end
         SELECT: begin
            spi_cs_n  = 1'b0;
            spi_mosi  = tx_q[TOT-1];
            state_nxt = SHIFT;
         end
         SHIFT: begin
            spi_cs_n = 1'b0;
            spi_sck  = phase_q;
            spi_mosi = tx_q[TOT-1];
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            wb_ack_o  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q     <= '0;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         we_q     <= 1'b0;
         rx_q     <= '0;
         wb_dat_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  we_q    <= wb_we_i;
                  tx_q    <= {(wb_we_i ? 8'h02 : 8'h03), wb_adr_i[ADDR_BITS-1:2],
                              (wb_we_i ? lane.off : 2'b00), (wb_we_i ? wr_data : 32'h0)};
                  cnt_q   <= CW'(8 + ADDR_BITS) + CW'({lane.nbytes, 3'b000});
                  phase_q <= 1'b0;
               end
            end
            SELECT: phase_q <= 1'b1;
            SHIFT: begin
               if (phase_q) begin
                  // End of high phase: sample miso, advance to the next bit.
                  tx_q    <= tx_q << 1;
                  rx_q    <= rx_nxt;
                  cnt_q   <= cnt_q - CW'(1);
                  phase_q <= 1'b0;
                  if (last_bit && !we_q)
                     wb_dat_o <= {rx_nxt[7:0], rx_nxt[15:8], rx_nxt[23:16], rx_nxt[31:24]};
               end else begin
                  phase_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_spi_mem.sv
// Directed bench for wb_spi_mem: table of single transactions plus reset-abort and back-to-back sequences.
module tb_wb_spi_mem;
   logic        clk;
   logic        rst;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic        wb_ack_o, spi_cs_n, spi_sck, spi_mosi, spi_miso;

   wb_spi_mem #(.ADDR_BITS(24)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] mw;
      bit          drop;
      int          ack;
      int          nb;
      logic [63:0] frame;
      logic [31:0] rdat;
   } vec_t;

   vec_t        vt[10];
   int          n_chk = 0;
   int          n_pass = 0;

   logic [31:0] mw[2];
   int          n_ack, nbits, cs_cnt, cs_first, cs_last;
   int          ack_at[4];
   logic [31:0] dat_at[4];
   logic [63:0] frame;
   bit          cs_hi_ok;
   logic        post_rst_cs, post_rst_sck;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Starts at a negedge; cycle 0 is the capture cycle, samples taken at each later negedge.
   task automatic run(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, input bit drop, input int acks_hold,
                      input int rst_at, input int max_cyc);
      int  bi, fi;
      bit  was_low;
      n_ack = 0; nbits = 0; frame = '0; cs_cnt = 0; cs_first = -1; cs_last = -1;
      cs_hi_ok = 1'b1; bi = 0; fi = 0; was_low = 1'b0;
      post_rst_cs = 1'bx; post_rst_sck = 1'bx;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_sel_i = sel;
      wb_adr_i = adr; wb_dat_i = dat;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (drop && c == 1) wb_stb_i = 1'b0;
         if (c == rst_at) rst = 1'b1;
         if (rst_at > 0 && c == rst_at + 1) begin
            rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            post_rst_cs = spi_cs_n; post_rst_sck = spi_sck;
         end
         if (!spi_cs_n) begin
            cs_cnt++;
            if (cs_first < 0) cs_first = c;
            cs_last = c;
            was_low = 1'b1;
         end else if (was_low) begin
            was_low = 1'b0; fi++; bi = 0;
         end
         if (spi_sck) begin
            if (fi == 0) begin
               frame = {frame[62:0], spi_mosi};
               nbits++;
            end
            spi_miso = (bi >= 32 && bi < 64 && fi < 2) ? mw[fi][31-(bi-32)] : 1'b0;
            bi++;
         end
         if (wb_ack_o) begin
            if (n_ack < 4) begin
               ack_at[n_ack] = c;
               dat_at[n_ack] = wb_dat_o;
            end
            if (spi_cs_n !== 1'b1) cs_hi_ok = 1'b0;
            n_ack++;
            if (n_ack >= acks_hold) begin
               wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
         end
      end
   endtask

   initial begin
      vt[0] = '{1'b0, 4'h0, 32'h4000_0010, 32'h0,         32'h1300_0593, 1'b0, 129, 64,
                64'h0300_0010_0000_0000, 32'h9305_0013};
      vt[1] = '{1'b1, 4'hC, 32'h8000_0006, 32'hBEEF_0000, 32'hFFFF_FFFF, 1'b0, 97,  48,
                64'h0000_0200_0006_EFBE, 32'h9305_0013};
      vt[2] = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_5A00, 32'hA5A5_A5A5, 1'b0, 81,  40,
                64'h0000_0002_0001_015A, 32'h9305_0013};
      vt[3] = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_5A00, 32'hA5A5_A5A5, 1'b1, 81,  40,
                64'h0000_0002_0001_015A, 32'h9305_0013};
      vt[4] = '{1'b1, 4'hF, 32'h00AB_CDE8, 32'h1122_3344, 32'h0F0F_0F0F, 1'b0, 129, 64,
                64'h02AB_CDE8_4433_2211, 32'h9305_0013};
      vt[5] = '{1'b1, 4'h5, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0,         1'b0, 1,   0,
                64'h0, 32'h9305_0013};
      vt[6] = '{1'b1, 4'h0, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0,         1'b0, 1,   0,
                64'h0, 32'h9305_0013};
      vt[7] = '{1'b1, 4'h8, 32'h0000_0020, 32'hA500_0000, 32'h0,         1'b0, 81,  40,
                64'h0000_0002_0000_23A5, 32'h9305_0013};
      vt[8] = '{1'b1, 4'h3, 32'h0000_0010, 32'h0000_CAFE, 32'h0,         1'b0, 97,  48,
                64'h0000_0200_0010_FECA, 32'h9305_0013};
      vt[9] = '{1'b0, 4'h0, 32'hFF12_3457, 32'h0,         32'hDEAD_BEEF, 1'b0, 129, 64,
                64'h0312_3454_0000_0000, 32'hEFBE_ADDE};

      rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_sel_i = '0; wb_adr_i = '0; wb_dat_i = '0; spi_miso = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack",  {63'd0, wb_ack_o}, 64'd0);
      chk("rst_dat",  {32'd0, wb_dat_o}, 64'd0);
      chk("rst_cs_n", {63'd0, spi_cs_n}, 64'd1);
      chk("rst_sck",  {63'd0, spi_sck},  64'd0);
      chk("rst_mosi", {63'd0, spi_mosi}, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         mw[0] = vt[i].mw; mw[1] = 32'h0;
         run(vt[i].we, vt[i].sel, vt[i].adr, vt[i].dat, vt[i].drop, 1, -1, 140);
         chk($sformatf("v%0d_ack_cnt", i),  n_ack, 1);
         chk($sformatf("v%0d_ack_cyc", i),  ack_at[0], vt[i].ack);
         chk($sformatf("v%0d_nbits", i),    nbits, vt[i].nb);
         chk($sformatf("v%0d_frame", i),    frame, vt[i].frame);
         chk($sformatf("v%0d_dat", i),      dat_at[0], vt[i].rdat);
         chk($sformatf("v%0d_cs_cnt", i),   cs_cnt, 2 * vt[i].nb);
         chk($sformatf("v%0d_cs_first", i), cs_first, (vt[i].nb > 0) ? 1 : -1);
         chk($sformatf("v%0d_cs_ack", i),   {63'd0, cs_hi_ok}, 64'd1);
      end

      // Reset in the middle of a read frame.
      mw[0] = 32'h1300_0593;
      run(1'b0, 4'h0, 32'h4000_0010, 32'h0, 1'b0, 1, 40, 200);
      chk("rst_mid_no_ack", n_ack, 0);
      chk("rst_mid_cs_n",   {63'd0, post_rst_cs},  64'd1);
      chk("rst_mid_sck",    {63'd0, post_rst_sck}, 64'd0);
      chk("rst_mid_cs_last", cs_last, 40);
      run(1'b0, 4'h0, 32'h4000_0010, 32'h0, 1'b0, 1, -1, 140);
      chk("post_rst_ack_cyc", ack_at[0], 129);
      chk("post_rst_dat",     dat_at[0], 32'h9305_0013);

      // Two reads with the request held through the first DONE.
      mw[0] = 32'h1122_3344; mw[1] = 32'h5566_7788;
      run(1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 2, -1, 270);
      chk("b2b_ack_cnt", n_ack, 2);
      chk("b2b_ack0",    ack_at[0], 129);
      chk("b2b_ack1",    ack_at[1], 259);
      chk("b2b_dat0",    dat_at[0], 32'h4433_2211);
      chk("b2b_dat1",    dat_at[1], 32'h8877_6655);
      chk("b2b_cs_ack",  {63'd0, cs_hi_ok}, 64'd1);
      chk("b2b_cs_cnt",  cs_cnt, 256);
      chk("b2b_frame",   frame, 64'h0300_0100_0000_0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
